// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package ifetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pair_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-to-decode handshake. if_fault exists only when IFETCH_ADDR_CHECK_EN is defined.
// Handshake: a pair transfers on a rising clk edge where if_valid && if_ready; while if_valid=1 and if_ready=0 the pair holds stable.
interface instr_fetch_if;
   import ifetch_pkg::*;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;
`ifdef IFETCH_ADDR_CHECK_EN
   logic            if_fault;

   modport master (output if_valid, output if_pc, output if_instr, output if_fault, input if_ready);
   modport slave  (input if_valid, input if_pc, input if_instr, input if_fault, output if_ready);
`else
   modport master (output if_valid, output if_pc, output if_instr, input if_ready);
   modport slave  (input if_valid, input if_pc, input if_instr, output if_ready);
`endif
endinterface

// File: rtl/fetch_fifo.sv
// Shift-register FIFO with a registered head; flush empties it in one cycle.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Entries shift toward slot 0 on pop, so the head is always a flop output.
   always_comb begin
      mem_d   = mem_q;
      count_d = count_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         count_d = '0;
      end else begin
         if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
            mem_d[DEPTH - 1] = '0;
            count_d = count_q - 1'b1;
         end
         if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (count_d == CW'(i)) mem_d[i] = push_data;
            end
            count_d = count_d + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign head_data = mem_q[0];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, combinational imem read, 2-entry pair buffer toward decode.
// Optional IFETCH_ADDR_CHECK_EN replaces out-of-range fetches with a NOP and flags if_fault.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter logic [31:0] PC_STEP    = 32'd4,
   parameter int          IMEM_WORDS = 64
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] read_address,
   input  logic [XLEN-1:0] instruction_in,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   instr_fetch_if.master   dec
);
   logic [XLEN-1:0] pc_q;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   fetch_pair_t     pair_in;
   fetch_pair_t     pair_out;

   // A redirect kills both directions, so the head being popped is not consumed.
   assign pop  = dec.if_valid && dec.if_ready && !redirect_valid;
   assign push = !redirect_valid && (!fifo_full || pop);

   assign read_address = pc_q;

`ifdef IFETCH_ADDR_CHECK_EN
   localparam int ENTRY_W = $bits(fetch_pair_t) + 1;
   localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS);
   logic               oob;
   logic [ENTRY_W-1:0] entry_in;
   logic [ENTRY_W-1:0] entry_out;

   assign oob     = (pc_q / PC_STEP) >= IMEM_LIMIT;
   assign pair_in = '{pc: pc_q, instr: (oob ? NOP_INSTR : instruction_in)};
   assign entry_in = {oob, pair_in};
   assign {dec.if_fault, pair_out} = entry_out;
`else
   localparam int ENTRY_W = $bits(fetch_pair_t);
   logic [ENTRY_W-1:0] entry_in;
   logic [ENTRY_W-1:0] entry_out;

   assign pair_in  = '{pc: pc_q, instr: instruction_in};
   assign entry_in = pair_in;
   assign pair_out = entry_out;
`endif

   fetch_fifo #(
      .DEPTH (2),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (entry_in),
      .pop       (pop),
      .head_data (entry_out),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign dec.if_valid = !fifo_empty;
   assign dec.if_pc    = pair_out.pc;
   assign dec.if_instr = pair_out.instr;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else if (redirect_valid) begin
         pc_q <= redirect_pc;
      end else if (push) begin
         pc_q <= pc_q + PC_STEP;
      end
   end
endmodule
